keypad_loader: RTL
==================

// Module: keypad_loader
// PURPOSE
//  Microwave front-end controller: writer side of the timer's digit-load port.
//  - Captures keypad digits (mm:ss) into a 3-digit entry buffer.
//  - On start, shifts them into the timer over data/loadn, oldest digit first.
//  - Then sequences timer enable (cook/pause/stop) from start, stop, door and the timer's zero flag.
// PARAMETERS
//  NDIG  3  digits in entry buffer and load burst (mins, sec_tens, sec_ones)
//  DW    4  BCD digit width
// PORTS
//  clk        in   1   system clock, rising edge
//  clrn       in   1   asynchronous active-low reset
//  key_digit  in   DW  keypad digit code, valid while key_valid=1
//  key_valid  in   1   keypad key-down level; one press per rising edge
//  start      in   1   start button level; acts on rising edge
//  stop       in   1   stop/clear button level; acts on rising edge
//  door_closed in  1   1 = door closed (level)
//  zero       in   1   timer count reached 00:00 (level from timer)
//  data       out  DW  digit presented to timer load port
//  loadn      out  1   active-low timer load strobe; one digit shifted in per low cycle
//  en         out  1   timer count enable, also magnetron on
//  tclrn      out  1   active-low one-cycle timer clear pulse
//  done       out  1   one-cycle pulse when cook completes
//  busy       out  1   1 in any state except IDLE
// BEHAVIOUR
//  Reset (clrn=0, async): state IDLE, buffer b2=b1=b0=0, edge regs 0, data=0, loadn=1, en=0, tclrn=1, done=0.
//  Edge detect: key_valid, start, stop registered once; event = cur & ~prev. Inputs are synchronous, no debounce.
//  Buffer, IDLE only: key event with key_digit<=9 -> b2<=b1, b1<=b0, b0<=key_digit.
//   Codes 10..15 ignored. No sec_tens range check.
//  States: IDLE, LOAD, COOK, PAUSE, DONE. Registered outputs.
//  Per-cycle event priority: stop > door open > zero > start > key.
//  IDLE:
//   - stop event -> clear buffer, tclrn=0 for 1 cycle, stay IDLE.
//   - start event & door_closed & buffer!=000 -> LOAD.
//   - start with door open or buffer==000 -> ignored.
//  LOAD: runs NDIG cycles, index k=0..2, all other inputs ignored.
//   - loadn=0 each cycle; data=b2, b1, b0 in that order.
//   - Timing: start event sampled cycle N -> loadn low cycles N+1..N+3 -> COOK, en=1 from cycle N+4.
//  COOK: en=1, loadn=1.
//   - stop -> IDLE, en=0, buffer cleared, tclrn pulse.
//   - door_closed=0 -> PAUSE, en=0 next cycle.
//   - zero=1 -> DONE.
//  PAUSE: en=0.
//   - start event & door_closed -> COOK (no reload; timer keeps count).
//   - stop -> IDLE as from COOK. Start with door open ignored.
//  DONE: one cycle, en=0, done=1, buffer cleared -> IDLE.
//  data holds last driven digit outside LOAD; loadn=1 outside LOAD.
//  zero=1 at LOAD exit: COOK still entered, DONE next cycle (en high 1 cycle).
//  Simultaneous key and start in IDLE: start wins, key dropped; burst uses pre-key buffer.
//  Held buttons produce one event only; re-press needs a low cycle.
//  Async reset mid-LOAD or mid-COOK: immediate return to reset values, partial burst abandoned.
// TESTING
//  1 Reset, keys 9,3,2, start (door closed) -> loadn low 3 cycles, data 9,3,2; en=1 cycle after; busy=1.
//  2 Keys 1,2,3,4 -> buffer b2..b0=2,3,4; key 12 -> buffer unchanged; start loads 2,3,4.
//  3 Cooking; door_closed=0 -> en=0 next cycle, PAUSE; start with door open -> no change;
//    door_closed=1 then start -> en=1, no loadn pulse.
//  4 Cooking; zero=1 -> done pulse 1 cycle, en=0, busy=0; start with empty buffer -> ignored.
//  5 Stop during COOK -> en=0, tclrn low exactly 1 cycle, buffer 000; stop and start same cycle -> stop wins.
//  6 clrn=0 during LOAD cycle 2 -> loadn=1, en=0, data=0 immediately; no further load cycles after release.

Source files
------------

// File: rtl/keypad_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_loader_if
//  Description : Digit-load / control link between the keypad loader and
//                the countdown timer.
//                  data  - digit presented to the timer load port
//                  loadn - active-low load strobe, one digit per low cycle
//                  en    - timer count enable (magnetron on)
//                  tclrn - active-low one-cycle timer clear
//                  zero  - timer has reached 00:00 (driven by the timer)
//                master = loader side, slave = timer side.
//  Revision    : 1.0  initial release
// ============================================================================
interface keypad_loader_if #(
    parameter int DW = 4
);
    logic [DW-1:0] data;
    logic          loadn;
    logic          en;
    logic          tclrn;
    logic          zero;

    modport master (
        output data,
        output loadn,
        output en,
        output tclrn,
        input  zero
    );

    modport slave (
        input  data,
        input  loadn,
        input  en,
        input  tclrn,
        output zero
    );
endinterface
`default_nettype wire

// File: rtl/keypad_loader.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_loader
//  Description : Microwave front-end controller. Captures keypad digits
//                (mm:ss) into an NDIG-digit entry buffer, shifts them into
//                the timer oldest-first on start, then sequences the timer
//                enable through cook / pause / stop / done.
//  Ports       : clk          system clock, rising edge
//                clrn         asynchronous active-low reset
//                key_digit    keypad digit code (valid while key_valid=1)
//                key_valid    key-down level, one press per rising edge
//                start, stop  button levels, act on rising edge
//                door_closed  1 = door closed
//                tmr          timer link (data/loadn/en/tclrn out, zero in)
//                done         one-cycle pulse when cooking completes
//                busy         1 in any state other than IDLE
//  Revision    : 1.0  initial release
// ============================================================================
module keypad_loader #(
    parameter int NDIG = 3,
    parameter int DW   = 4
) (
    input  wire logic          clk,
    input  wire logic          clrn,
    input  wire logic [DW-1:0] key_digit,
    input  wire logic          key_valid,
    input  wire logic          start,
    input  wire logic          stop,
    input  wire logic          door_closed,
    keypad_loader_if.master    tmr,
    output logic               done,
    output logic               busy
);

    localparam int KW = $clog2(NDIG + 1);
    localparam int BW = NDIG * DW;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        COOK  = 3'd2,
        PAUSE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   buf_q, buf_d;      // oldest digit in the top DW bits
    logic [KW-1:0]   k_q, k_d;          // next digit index during LOAD
    logic [DW-1:0]   data_q, data_d;
    logic            loadn_q, loadn_d;
    logic            en_q, en_d;
    logic            tclrn_q, tclrn_d;
    logic            done_q, done_d;
    logic            key_prev, start_prev, stop_prev;

    logic            key_ev, start_ev, stop_ev, key_ok, buf_nz;
    logic [DW-1:0]   sel_digit;

    assign key_ev   = key_valid & ~key_prev;
    assign start_ev = start & ~start_prev;
    assign stop_ev  = stop & ~stop_prev;
    assign key_ok   = key_ev && (key_digit <= DW'(9));
    assign buf_nz   = |buf_q;

    // Digit k of the burst, counted from the oldest entry.
    always_comb begin
        sel_digit = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (KW'(i) == k_q) begin
                sel_digit = buf_q[(NDIG-1-i)*DW +: DW];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        k_d     = k_q;
        data_d  = data_q;
        loadn_d = 1'b1;
        en_d    = en_q;
        tclrn_d = 1'b1;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                en_d = 1'b0;
                if (stop_ev) begin
                    buf_d   = '0;
                    tclrn_d = 1'b0;
                end else if (start_ev && door_closed && buf_nz) begin
                    // First burst digit goes out on the cycle after the start
                    // event; a simultaneous key press is dropped.
                    state_d = LOAD;
                    loadn_d = 1'b0;
                    data_d  = buf_q[BW-1 -: DW];
                    k_d     = KW'(1);
                end else if (key_ok) begin
                    buf_d = {buf_q[BW-DW-1:0], key_digit};
                end
            end

            LOAD: begin
                if (k_q < KW'(NDIG)) begin
                    loadn_d = 1'b0;
                    data_d  = sel_digit;
                    k_d     = k_q + KW'(1);
                end else begin
                    // Enter COOK regardless of zero; it is acted on from COOK.
                    state_d = COOK;
                    en_d    = 1'b1;
                    k_d     = '0;
                end
            end

            COOK: begin
                en_d = 1'b1;
                if (stop_ev) begin
                    state_d = IDLE;
                    en_d    = 1'b0;
                    buf_d   = '0;
                    tclrn_d = 1'b0;
                end else if (!door_closed) begin
                    state_d = PAUSE;
                    en_d    = 1'b0;
                end else if (tmr.zero) begin
                    state_d = DONE;
                    en_d    = 1'b0;
                    done_d  = 1'b1;
                end
            end

            PAUSE: begin
                en_d = 1'b0;
                if (stop_ev) begin
                    state_d = IDLE;
                    buf_d   = '0;
                    tclrn_d = 1'b0;
                end else if (start_ev && door_closed) begin
                    // Resume without reload: the timer kept its count.
                    state_d = COOK;
                    en_d    = 1'b1;
                end
            end

            DONE: begin
                state_d = IDLE;
                en_d    = 1'b0;
                buf_d   = '0;
            end

            default: begin
                state_d = IDLE;
                en_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q    <= IDLE;
            buf_q      <= '0;
            k_q        <= '0;
            data_q     <= '0;
            loadn_q    <= 1'b1;
            en_q       <= 1'b0;
            tclrn_q    <= 1'b1;
            done_q     <= 1'b0;
            key_prev   <= 1'b0;
            start_prev <= 1'b0;
            stop_prev  <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            k_q        <= k_d;
            data_q     <= data_d;
            loadn_q    <= loadn_d;
            en_q       <= en_d;
            tclrn_q    <= tclrn_d;
            done_q     <= done_d;
            key_prev   <= key_valid;
            start_prev <= start;
            stop_prev  <= stop;
        end
    end

    assign tmr.data  = data_q;
    assign tmr.loadn = loadn_q;
    assign tmr.en    = en_q;
    assign tmr.tclrn = tclrn_q;
    assign done      = done_q;
    assign busy      = (state_q != IDLE);

endmodule
`default_nettype wire
